axi_imem_rd_slave: RTL and testbench

- AXI4 read-channel responder that sits in front of the instruction memory array and serves fetch requests issued by the instruction-cache controller.
- Accepts one AR transaction at a time and returns arlen+1 beats on the R channel, supporting FIXED, INCR and WRAP bursts.
- Includes a simple word-write load port so benches and the boot loader can preload program contents.

---
 rtl/axi_imem_rd_slave.sv | 205 ++++++++++++++++++++
 tb/tb_axi_imem_rd_slave.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_imem_rd_slave.sv
// -----------------------------------------------------------------------------
// axi_imem_rd_slave
//
// AXI4 read-channel responder in front of the instruction memory array. It
// serves fetch requests from the instruction-cache controller one AR
// transaction at a time and returns arlen+1 beats using FIXED, INCR or WRAP
// addressing. A word-write load port lets the boot loader or a bench preload
// program contents.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   araddr/arvalid/arready     AR address and handshake
//   arburst/arsize/arlen       burst type, beat size (only 4 bytes legal),
//                              beats minus one
//   arcache                    accepted but unused
//   rdata/rresp/rvalid/rlast   R data, response (OKAY/SLVERR), valid, last
//   rready                     R ready from the master
//   ld_en/ld_addr/ld_data      load-port word write (word index, data)
// -----------------------------------------------------------------------------
module axi_imem_rd_slave #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      araddr,
  input  logic             arvalid,
  output logic             arready,
  input  logic [1:0]       arburst,
  input  logic [2:0]       arsize,
  input  logic [7:0]       arlen,
  input  logic [2:0]       arcache,
  output logic [31:0]      rdata,
  output logic [1:0]       rresp,
  output logic             rvalid,
  output logic             rlast,
  input  logic             rready,
  input  logic             ld_en,
  input  logic [IDX_W-1:0] ld_addr,
  input  logic [31:0]      ld_data
);

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [31:0] mem [DEPTH];

  state_e      state_q,   state_d;
  logic [31:0] addr_q,    addr_d;
  logic [1:0]  burst_q,   burst_d;     // advance mode actually applied
  logic [7:0]  len_q,     len_d;
  logic [7:0]  cnt_q,     cnt_d;
  logic        cfg_err_q, cfg_err_d;   // burst-wide error, fixed at accept
  logic [31:0] rdata_q,   rdata_d;
  logic [1:0]  rresp_q,   rresp_d;
  logic        rlast_q,   rlast_d;

  logic             wrap_len_ok;
  logic             ar_cfg_err;
  logic [1:0]       ar_burst_eff;
  logic [31:0]      wrap_mask;
  logic [31:0]      next_addr;
  logic             load_beat;
  logic [31:0]      beat_addr;
  logic             beat_cfg_err;
  logic             beat_err;
  logic [IDX_W-1:0] beat_idx;

  // arcache carries no meaning for this memory.
  logic unused_arcache;
  assign unused_arcache = ^arcache;

  // AR decode: request-level error conditions and the advance mode to use.
  // Reserved and malformed WRAP bursts walk the address like INCR.
  always_comb begin
    wrap_len_ok  = (arlen == 8'd1) || (arlen == 8'd3) ||
                   (arlen == 8'd7) || (arlen == 8'd15);
    ar_cfg_err   = (arsize != 3'd2) || (arburst == BURST_RSVD) ||
                   ((arburst == BURST_WRAP) && !wrap_len_ok);
    ar_burst_eff = arburst;
    if ((arburst == BURST_RSVD) || ((arburst == BURST_WRAP) && !wrap_len_ok)) begin
      ar_burst_eff = BURST_INCR;
    end
  end

  // Address of the beat after the current one. For WRAP the legal lengths
  // make (len+1)*4 a power of two, so {len,2'b11} is the in-block offset mask.
  always_comb begin
    wrap_mask = {22'd0, len_q, 2'b11};
    unique case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) | ((addr_q + 32'd4) & wrap_mask);
      default:     next_addr = addr_q + 32'd4;
    endcase
  end

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    burst_d      = burst_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    cfg_err_d    = cfg_err_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    rlast_d      = rlast_q;
    load_beat    = 1'b0;
    beat_addr    = araddr;
    beat_cfg_err = ar_cfg_err;

    unique case (state_q)
      ST_IDLE: begin
        if (arvalid) begin
          addr_d    = araddr;
          burst_d   = ar_burst_eff;
          len_d     = arlen;
          cnt_d     = 8'd0;
          cfg_err_d = ar_cfg_err;
          rlast_d   = (arlen == 8'd0);
          load_beat = 1'b1;
          state_d   = ST_BURST;
        end
      end
      ST_BURST: begin
        if (rready) begin
          if (rlast_q) begin
            rlast_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            // Next beat is registered on the same edge that retires this one,
            // keeping back-to-back beats at one per cycle.
            addr_d       = next_addr;
            cnt_d        = cnt_q + 8'd1;
            rlast_d      = ((cnt_q + 8'd1) == len_q);
            beat_addr    = next_addr;
            beat_cfg_err = cfg_err_q;
            load_beat    = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Beat registration. The array read sees pre-edge contents, so a load to
    // the same word on this edge is returned on the following registration.
    beat_err = beat_cfg_err || ((beat_addr >> (IDX_W + 2)) != 32'd0);
    beat_idx = beat_addr[IDX_W+1:2];
    if (load_beat) begin
      rresp_d = beat_err ? RESP_SLVERR : RESP_OKAY;
      rdata_d = beat_err ? 32'd0 : mem[beat_idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= 32'd0;
      burst_q   <= BURST_INCR;
      len_q     <= 8'd0;
      cnt_q     <= 8'd0;
      cfg_err_q <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      burst_q   <= burst_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= cfg_err_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  // NOTE: the array has no reset; program contents survive rst_n and a reset
  // port on a memory would prevent mapping it onto RAM.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  assign arready = (state_q == ST_IDLE);
  assign rvalid  = (state_q == ST_BURST);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;

endmodule

// File: tb/tb_axi_imem_rd_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_imem_rd_slave
//
// Directed bench for axi_imem_rd_slave. Expected R beats are computed from a
// reference model of the memory when an AR is issued, queued, and compared as
// each R handshake occurs.
// -----------------------------------------------------------------------------
module tb_axi_imem_rd_slave;

  localparam int DEPTH = 1024;
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      araddr = '0;
  logic             arvalid = 1'b0;
  logic             arready;
  logic [1:0]       arburst = '0;
  logic [2:0]       arsize = '0;
  logic [7:0]       arlen = '0;
  logic [2:0]       arcache = '0;
  logic [31:0]      rdata;
  logic [1:0]       rresp;
  logic             rvalid;
  logic             rlast;
  logic             rready = 1'b0;
  logic             ld_en = 1'b0;
  logic [IDX_W-1:0] ld_addr = '0;
  logic [31:0]      ld_data = '0;

  axi_imem_rd_slave #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .arburst (arburst),
    .arsize  (arsize),
    .arlen   (arlen),
    .arcache (arcache),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rlast   (rlast),
    .rready  (rready),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  always #5 clk = ~clk;

  beat_t       exp_q[$];
  logic [31:0] model_mem [DEPTH];
  int          tests = 0;
  int          fails = 0;
  int          beat_no = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: expected beats for one AR.
  task automatic push_burst(input logic [31:0] addr, input logic [1:0] burst,
                            input logic [2:0] size, input logic [7:0] len);
    logic        cfg_err;
    logic        wrap_ok;
    logic [31:0] bytes;
    logic [31:0] off;
    logic [31:0] a;
    beat_t       b;
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    cfg_err = (size != 3'd2) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_ok);
    bytes   = (32'(len) + 32'd1) * 32'd4;
    off     = addr % bytes;
    for (int i = 0; i <= int'(len); i++) begin
      if (burst == 2'b00)                a = addr;
      else if (burst == 2'b10 && wrap_ok) a = addr - off + ((off + 32'(4 * i)) % bytes);
      else                               a = addr + 32'(4 * i);
      b.last = (i == int'(len));
      if (cfg_err || (a >= 32'(DEPTH * 4))) begin
        b.data = 32'd0;
        b.resp = 2'b10;
      end else begin
        b.data = model_mem[a[IDX_W+1:2]];
        b.resp = 2'b00;
      end
      exp_q.push_back(b);
    end
  endtask

  // One cycle: consume an R beat if a handshake is pending, then step to
  // just after the next rising edge.
  task automatic tick();
    beat_t got;
    beat_t exp;
    @(negedge clk);
    if (rst_n && rvalid && rready) begin
      got = {rdata, rresp, rlast};
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'(exp_q.size()), 64'd1);
      end else begin
        exp = exp_q.pop_front();
        check($sformatf("beat%0d", beat_no), 64'(got), 64'(exp));
      end
      beat_no++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int idx, input logic [31:0] val);
    ld_en   = 1'b1;
    ld_addr = IDX_W'(idx);
    ld_data = val;
    model_mem[idx] = val;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [1:0] burst,
                         input logic [2:0] size, input logic [7:0] len);
    logic accepted;
    accepted = 1'b0;
    push_burst(addr, burst, size, len);
    araddr  = addr;
    arburst = burst;
    arsize  = size;
    arlen   = len;
    arvalid = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      accepted = arready;
      tick();
    end
    arvalid = 1'b0;
    check("ar_accepted", 64'(accepted), 64'd1);
    check("rvalid_latency1", 64'(rvalid), 64'd1);
    check("arready_low_in_burst", 64'(arready), 64'd0);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((rvalid || exp_q.size() != 0) && n < 600) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_rvalid_low"}, 64'(rvalid), 64'd0);
    check({tag, "_arready_high"}, 64'(arready), 64'd1);
  endtask

  initial begin
    // Reset state.
    #23;
    check("rst_arready", 64'(arready), 64'd1);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rlast", 64'(rlast), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_rresp", 64'(rresp), 64'd0);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Preload the whole array, then the directed words.
    for (int i = 0; i < DEPTH; i++) load_word(i, (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000);
    load_word(0, 32'h11);
    load_word(1, 32'h22);
    load_word(2, 32'h33);
    load_word(3, 32'h44);
    load_word(DEPTH - 1, 32'hDEAD_BEEF);

    // Single-beat INCR.
    rready = 1'b1;
    send_ar(32'h0, 2'b01, 3'd2, 8'd0);
    check("t1_rdata", 64'(rdata), 64'h11);
    check("t1_rlast", 64'(rlast), 64'd1);
    wait_done("t1");

    // INCR with a two-cycle stall on beat 1.
    send_ar(32'h4, 2'b01, 3'd2, 8'd2);
    tick();
    rready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall_rdata", 64'(rdata), 64'h33);
      check("stall_rvalid", 64'(rvalid), 64'd1);
      check("stall_rlast", 64'(rlast), 64'd0);
    end
    rready = 1'b1;
    wait_done("t2");

    // WRAP and FIXED.
    send_ar(32'hC, 2'b10, 3'd2, 8'd3);
    wait_done("wrap");
    send_ar(32'h8, 2'b00, 3'd2, 8'd2);
    wait_done("fixed");

    // Error cases: top-of-memory crossing, bad size, reserved, bad WRAP length.
    send_ar(32'(DEPTH * 4 - 4), 2'b01, 3'd2, 8'd1);
    wait_done("top_edge");
    send_ar(32'h0, 2'b01, 3'd1, 8'd1);
    wait_done("bad_size");
    send_ar(32'h4, 2'b11, 3'd2, 8'd1);
    wait_done("rsvd_burst");
    send_ar(32'h0, 2'b10, 3'd2, 8'd2);
    wait_done("bad_wrap_len");

    // Load to word 1 on the edge that retires beat 0 and registers beat 1.
    send_ar(32'h0, 2'b01, 3'd2, 8'd1);
    ld_en   = 1'b1;
    ld_addr = IDX_W'(1);
    ld_data = 32'hAA;
    tick();
    ld_en = 1'b0;
    model_mem[1] = 32'hAA;
    wait_done("same_cycle_ld");
    send_ar(32'h4, 2'b01, 3'd2, 8'd0);
    wait_done("after_ld");

    // Longest INCR burst.
    send_ar(32'h0, 2'b01, 3'd2, 8'd255);
    wait_done("len255");

    // Reset during beat 2 of an 8-beat INCR.
    send_ar(32'h0, 2'b01, 3'd2, 8'd7);
    tick();
    tick();
    check("pre_rst_beat2", 64'(rdata), 64'h33);
    rst_n = 1'b0;
    #1;
    check("midrst_rvalid", 64'(rvalid), 64'd0);
    check("midrst_arready", 64'(arready), 64'd1);
    check("midrst_rlast", 64'(rlast), 64'd0);
    exp_q.delete();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_rvalid", 64'(rvalid), 64'd0);
    send_ar(32'h8, 2'b01, 3'd2, 8'd1);
    wait_done("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
